seq_adder: RTL and testbench

SEQ_ADDER -- requirements
Module: seq_adder

---
 rtl/seq_adder.sv | 86 ++++++++
 tb/tb_seq_adder.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/seq_adder.sv
// seq_adder: multi-cycle adder/subtractor that adds one CHUNK-bit slice per clock
//   Parameters: WIDTH operand/result width, CHUNK bits per cycle (WIDTH % CHUNK == 0)
//   Ports: clk, reset (sync, active-high), start, a, b, cin, sub -> busy, done, sum, cout, ovf
//   Optional: define SEQ_ADDER_ZERO_FLAG_EN to add output zero (completed sum == 0)
module seq_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
`ifdef SEQ_ADDER_ZERO_FLAG_EN
    ,output logic            zero
`endif
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, nstate;
    logic [WIDTH-1:0] opa, opb, acc, nxt;
    logic [IW-1:0] idx;
    logic carry, last, accept;
    logic [CHUNK:0] sl;
    assign busy = state == RUN;
    assign done = state == DONE;
    assign last = idx == IW'(NCHUNK - 1);
    assign accept = start && state != RUN;
    always_comb begin
        sl = {1'b0, opa[idx*CHUNK +: CHUNK]} + {1'b0, opb[idx*CHUNK +: CHUNK]} + {{CHUNK{1'b0}}, carry};
        nxt = acc;
        nxt[idx*CHUNK +: CHUNK] = sl[CHUNK-1:0];
    end
    // DONE accepts a new start exactly like IDLE, enabling back-to-back ops
    always_comb begin
        nstate = state == RUN ? (last ? DONE : RUN) : (start ? RUN : IDLE);
    end
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= nstate;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            opa <= '0;
            opb <= '0;
            acc <= '0;
            idx <= '0;
            carry <= 1'b0;
            sum <= '0;
            cout <= 1'b0;
            ovf <= 1'b0;
`ifdef SEQ_ADDER_ZERO_FLAG_EN
            zero <= 1'b0;
`endif
        end else if (accept) begin
            opa <= a;
            opb <= sub ? ~b : b;
            carry <= sub | cin;
            acc <= '0;
            idx <= '0;
        end else if (state == RUN) begin
            acc <= nxt;
            carry <= sl[CHUNK];
            idx <= idx + 1'b1;
            if (last) begin
                sum <= nxt;
                cout <= sl[CHUNK];
                // a^b^s at the MSB recovers the carry into the MSB
                ovf <= sl[CHUNK] ^ opa[WIDTH-1] ^ opb[WIDTH-1] ^ nxt[WIDTH-1];
`ifdef SEQ_ADDER_ZERO_FLAG_EN
                zero <= nxt == '0;
`endif
            end
        end
    end
endmodule

// File: tb/tb_seq_adder.sv
// tb_seq_adder: directed table-driven check of seq_adder (WIDTH=8, CHUNK=4)
module tb_seq_adder;
    logic clk = 1'b0, reset = 1'b1, start = 1'b0, cin = 1'b0, sub = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic busy, done, cout, ovf;
    logic [7:0] sum;
`ifdef SEQ_ADDER_ZERO_FLAG_EN
    logic zero;
`endif
    int checks = 0, errors = 0;
    typedef struct {
        logic [7:0] a, b;
        logic cin, sub;
        logic [7:0] s;
        logic c, v;
    } vec_t;
    vec_t vt[12];
    logic [7:0] prev = '0;

    seq_adder #(.WIDTH(8), .CHUNK(4)) dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
`ifdef SEQ_ADDER_ZERO_FLAG_EN
        , .zero(zero)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_op(input vec_t v);
        int lat;
        lat = 0;
        a = v.a; b = v.b; cin = v.cin; sub = v.sub; start = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (n == 1) begin
                start = 1'b0;
                a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); sub = 1'($urandom);
            end
            if (done) begin
                lat = n;
                break;
            end
            chk("busy", busy, 1);
            chk("hold", sum, prev);
        end
        chk("latency", lat, 3);
        chk("busy_at_done", busy, 0);
        chk("sum", sum, v.s);
        chk("cout", cout, v.c);
        chk("ovf", ovf, v.v);
`ifdef SEQ_ADDER_ZERO_FLAG_EN
        chk("zero", zero, v.s == 8'h00);
`endif
        prev = v.s;
        @(negedge clk);
        chk("done_pulse", done, 0);
    endtask

    initial begin
        int nd, lat;
        vt[0]  = '{8'h3C, 8'h0F, 0, 0, 8'h4B, 0, 0};
        vt[1]  = '{8'hFF, 8'h01, 0, 0, 8'h00, 1, 0};
        vt[2]  = '{8'h7F, 8'h01, 0, 0, 8'h80, 0, 1};
        vt[3]  = '{8'h05, 8'h07, 0, 1, 8'hFE, 0, 0};
        vt[4]  = '{8'h80, 8'h80, 0, 0, 8'h00, 1, 1};
        vt[5]  = '{8'h0F, 8'h00, 1, 0, 8'h10, 0, 0};
        vt[6]  = '{8'h10, 8'h10, 0, 1, 8'h00, 1, 0};
        vt[7]  = '{8'h80, 8'h01, 0, 1, 8'h7F, 1, 1};
        vt[8]  = '{8'hFF, 8'hFF, 1, 0, 8'hFF, 1, 0};
        vt[9]  = '{8'h00, 8'h01, 0, 1, 8'hFF, 0, 0};
        vt[10] = '{8'h7F, 8'hFF, 0, 1, 8'h80, 0, 1};
        vt[11] = '{8'h05, 8'h03, 1, 1, 8'h02, 1, 0};
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        chk("rst_ovf", ovf, 0);
        start = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 12; i++) do_op(vt[i]);

        // second start while busy is dropped
        a = 8'h10; b = 8'h20; cin = 0; sub = 0; start = 1'b1;
        @(negedge clk);
        a = 8'hFF; b = 8'hFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nd = 0;
        for (int n = 0; n < 8; n++) begin
            if (done) nd++;
            @(negedge clk);
        end
        chk("drop_dones", nd, 1);
        chk("drop_sum", sum, 8'h30);
        chk("drop_busy", busy, 0);
        prev = 8'h30;

        // reset aborts an in-flight op
        a = 8'h7F; b = 8'h7F; start = 1'b1;
        @(negedge clk);
        start = 1'b0; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_sum", sum, 0);
        nd = 0;
        for (int n = 0; n < 5; n++) begin
            if (done) nd++;
            @(negedge clk);
        end
        chk("abort_dones", nd, 0);
        prev = 8'h00;
        do_op('{8'h01, 8'h02, 0, 0, 8'h03, 0, 0});

        // start held high: back-to-back ops every third cycle
        vt[0] = '{8'h01, 8'h01, 0, 0, 8'h02, 0, 0};
        vt[1] = '{8'h20, 8'h30, 0, 0, 8'h50, 0, 0};
        vt[2] = '{8'h7F, 8'h01, 0, 0, 8'h80, 0, 1};
        vt[3] = '{8'hC0, 8'hC0, 0, 0, 8'h80, 1, 0};
        a = vt[0].a; b = vt[0].b; cin = 0; sub = 0; start = 1'b1;
        for (int k = 0; k < 4; k++) begin
            lat = 0;
            for (int n = 1; n <= 10; n++) begin
                @(negedge clk);
                if (done) begin
                    lat = n;
                    break;
                end
            end
            chk("b2b_latency", lat, 3);
            chk("b2b_sum", sum, vt[k].s);
            chk("b2b_cout", cout, vt[k].c);
            chk("b2b_ovf", ovf, vt[k].v);
            if (k < 3) begin
                a = vt[k+1].a; b = vt[k+1].b;
            end else
                start = 1'b0;
        end
        @(negedge clk);
        chk("b2b_idle", busy | done, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
